// File: rtl/fetch_queue.sv
// Instruction-fetch front end. It owns the fetch PC and issues pipelined reads to a
// variable-latency instruction memory. Returned words are buffered with their PCs in
// an in-order queue that feeds the IF/ID register. A taken redirect flushes the queue
// and discards every response still in flight.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        o_valid,
  output logic [31:0] o_com,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [31:0]   r_com_mem [DEPTH];
  logic [31:0]   r_pc_mem  [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;

  logic [CW:0]   w_in_use;
  logic          w_credit;
  logic          w_issue;
  logic          w_resp;
  logic          w_drop;
  logic          w_push;
  logic          w_valid;
  logic          w_pop;
  logic [31:0]   w_target;
  logic          w_unused_tgt_lsb;

  // Queued entries plus reads in flight may never exceed the queue size, so every
  // response that is kept is guaranteed a free slot.
  assign w_in_use = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_credit = w_in_use < (CW+1)'(DEPTH);

  assign imem_req  = !rst && !redirect && w_credit;
  assign imem_addr = r_fetch_pc;
  assign w_issue   = imem_req && imem_ack;

  // A response with nothing outstanding belongs to a request from before reset.
  assign w_resp = !rst && imem_rvalid && (r_outstanding != '0);
  assign w_drop = w_resp && (r_drop_cnt != '0);
  assign w_push = w_resp && !w_drop && !redirect;

  assign w_valid = !rst && (r_count != '0);
  assign w_pop   = w_valid && !stall && !redirect;

  assign w_target         = {redirect_target[31:2], 2'b00};
  assign w_unused_tgt_lsb = &{1'b0, redirect_target[1:0]};

  // Head entry goes straight out of the storage array; no read latency.
  assign o_valid    = w_valid;
  assign o_com      = w_valid ? r_com_mem[r_rd_ptr] : 32'h0;
  assign o_pc       = w_valid ? r_pc_mem[r_rd_ptr] : 32'h0;
  assign o_pc_plus4 = w_valid ? (r_pc_mem[r_rd_ptr] + 32'd4) : 32'h0;

  // PCs, pointers and the three credit counters; redirect overrides everything else.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect) begin
      // Every read not returned by the end of this cycle is now stale, including
      // those already marked for drop; a response arriving now is discarded too.
      r_fetch_pc    <= w_target;
      r_resp_pc     <= w_target;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= r_outstanding - CW'(w_resp);
      r_drop_cnt    <= r_outstanding - CW'(w_resp);
    end else begin
      if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_resp);
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt - CW'(1);
      end
      if (w_push) begin
        r_resp_pc <= r_resp_pc + 32'd4;
        r_wr_ptr  <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Queue payload: instruction word and the PC it was fetched from.
  // NOTE: the storage array has no reset; r_count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_com_mem[r_wr_ptr] <= imem_rdata;
      r_pc_mem[r_wr_ptr]  <= r_resp_pc;
    end
  end

  // The credit rule should make an overflowing push impossible.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(w_push && (r_count == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue. A behavioural memory responder and an
// epoch-tagged fetch-stream model predict every output each cycle.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] HI_PC = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          ready;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ack, imem_rvalid, redirect, stall;
  logic [31:0] imem_addr, imem_rdata, redirect_target;
  logic        o_valid;
  logic [31:0] o_com, o_pc, o_pc_plus4;

  logic        hi_req, hi_rvalid, hi_valid;
  logic [31:0] hi_addr, hi_rdata, hi_com, hi_pc, hi_pc_plus4;

  fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_target(redirect_target), .stall(stall),
    .o_valid(o_valid), .o_com(o_com), .o_pc(o_pc), .o_pc_plus4(o_pc_plus4)
  );

  // Second instance exercises a reset PC that wraps through zero.
  fetch_queue #(.RESET_PC(HI_PC), .DEPTH(DEPTH)) u_dut_hi (
    .clk(clk), .rst(rst),
    .imem_req(hi_req), .imem_addr(hi_addr), .imem_ack(1'b1),
    .imem_rvalid(hi_rvalid), .imem_rdata(hi_rdata),
    .redirect(1'b0), .redirect_target(32'h0), .stall(1'b0),
    .o_valid(hi_valid), .o_com(hi_com), .o_pc(hi_pc), .o_pc_plus4(hi_pc_plus4)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          epoch    = 0;
  int          acc_cnt  = 0;
  logic [31:0] gold_fetch;
  logic [31:0] q[$];
  req_t        pend[$];

  int ack_pct, rv_pct, stall_pct, lat_max;
  bit rv_block, spur_en;

  logic        last_valid, last_req;
  logic [31:0] last_pc, last_addr;

  logic        hi_acc = 1'b0;
  logic [31:0] hi_acc_addr = 32'h0;
  logic [31:0] hi_seen_pc[3];
  logic [31:0] hi_seen_p4[3];
  int          hi_seen = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    n_checks++;
    if (obs !== expected) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, obs, expected);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; imem_ack = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    stall = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
    hi_rvalid = 1'b0; hi_rdata = 32'h0; hi_acc = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("rst_req",   imem_req,   32'h0);
      check("rst_valid", o_valid,    32'h0);
      check("rst_pc",    o_pc,       32'h0);
      check("rst_com",   o_com,      32'h0);
      check("rst_plus4", o_pc_plus4, 32'h0);
      @(posedge clk); #1; cyc++;
    end
    rst = 1'b0;
    q.delete(); pend.delete();
    gold_fetch = 32'h0; epoch++; acc_cnt = 0;
  endtask

  // One clock: drive inputs, compare outputs at the falling edge, advance the model.
  task automatic run_cycle(input bit redir, input logic [31:0] tgt);
    logic ak, st, rv, exp_req;
    req_t p;
    ak = ($urandom_range(99) < ack_pct);
    st = ($urandom_range(99) < stall_pct);
    rv = 1'b0;
    if (pend.size() > 0) begin
      if (!rv_block && pend[0].ready <= cyc && $urandom_range(99) < rv_pct) rv = 1'b1;
    end else if (spur_en && $urandom_range(7) == 0) begin
      rv = 1'b1;
    end
    imem_ack = ak; stall = st; redirect = redir; redirect_target = tgt;
    imem_rvalid = rv;
    imem_rdata  = (rv && pend.size() > 0) ? mem_word(pend[0].addr) : $urandom();
    hi_rvalid   = hi_acc;
    hi_rdata    = mem_word(hi_acc_addr);

    @(negedge clk);
    exp_req = !redir && ((q.size() + pend.size()) < DEPTH);
    check("imem_req", imem_req, exp_req);
    if (exp_req) check("imem_addr", imem_addr, gold_fetch);
    check("o_valid", o_valid, q.size() > 0);
    check("o_pc",    o_pc,       (q.size() > 0) ? q[0] : 32'h0);
    check("o_com",   o_com,      (q.size() > 0) ? mem_word(q[0]) : 32'h0);
    check("o_plus4", o_pc_plus4, (q.size() > 0) ? q[0] + 32'd4 : 32'h0);
    last_valid = o_valid; last_pc = o_pc; last_req = imem_req; last_addr = imem_addr;

    hi_acc = hi_req; hi_acc_addr = hi_addr;
    if (hi_valid && hi_seen < 3) begin
      hi_seen_pc[hi_seen] = hi_pc;
      hi_seen_p4[hi_seen] = hi_pc_plus4;
      hi_seen++;
    end

    if (redir) begin
      q.delete();
      epoch++;
      if (rv && pend.size() > 0) void'(pend.pop_front());
      gold_fetch = {tgt[31:2], 2'b00};
    end else begin
      if (q.size() > 0 && !st) void'(q.pop_front());
      if (rv && pend.size() > 0) begin
        p = pend.pop_front();
        if (p.epoch == epoch) q.push_back(p.addr);
      end
      if (exp_req && ak) begin
        p.addr = gold_fetch; p.epoch = epoch;
        p.ready = cyc + 1 + int'($urandom_range(lat_max));
        pend.push_back(p);
        gold_fetch += 32'd4;
        acc_cnt++;
      end
    end
    check("credit", (q.size() + pend.size()) <= DEPTH, 32'h1);
    @(posedge clk); #1; cyc++;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    int n = 0;
    do begin run_cycle(1'b0, 32'h0); n++; end while (!last_valid && n < 20);
    check(tag, last_pc, exp_pc);
  endtask

  initial begin
    int first_valid;
    ack_pct = 100; rv_pct = 100; stall_pct = 0; lat_max = 0;
    rv_block = 1'b0; spur_en = 1'b0;

    // 1: streaming, one PC per cycle from cycle 2
    do_reset(2);
    first_valid = -1;
    for (int k = 0; k < 12; k++) begin
      run_cycle(1'b0, 32'h0);
      if (last_valid && first_valid < 0) first_valid = k;
    end
    check("t1_latency", first_valid, 32'd2);

    // 5: wrapping reset PC on the second instance
    check("t5_pc0",   hi_seen_pc[0], 32'hFFFF_FFF8);
    check("t5_pc1",   hi_seen_pc[1], 32'hFFFF_FFFC);
    check("t5_pc2",   hi_seen_pc[2], 32'h0000_0000);
    check("t5_plus4", hi_seen_p4[2], 32'h0000_0004);

    // 2: stall held fills the queue then blocks issue
    do_reset(1);
    stall_pct = 100;
    repeat (10) run_cycle(1'b0, 32'h0);
    check("t2_issued", acc_cnt, 32'd4);
    check("t2_req",    last_req, 32'h0);
    check("t2_hold",   last_pc, 32'h0);
    stall_pct = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 32'h0);
      check("t2_pop", last_pc, 32'(4 * i));
    end

    // 3: redirect with two reads in flight
    do_reset(1);
    rv_block = 1'b1;
    repeat (2) run_cycle(1'b0, 32'h0);
    run_cycle(1'b1, 32'h0000_0103);
    rv_block = 1'b0;
    run_cycle(1'b0, 32'h0);
    check("t3_empty", last_valid, 32'h0);
    check("t3_req",   last_req, 32'h1);
    check("t3_addr",  last_addr, 32'h0000_0100);
    wait_valid("t3_first_pc", 32'h0000_0100);

    // 4: redirect, stall and a response in the same cycle
    do_reset(1);
    repeat (3) run_cycle(1'b0, 32'h0);
    stall_pct = 100;
    run_cycle(1'b1, 32'h0000_0200);
    stall_pct = 0;
    run_cycle(1'b0, 32'h0);
    check("t4_empty", last_valid, 32'h0);
    wait_valid("t4_first_pc", 32'h0000_0200);

    // 6: random latencies, stalls, redirects and one mid-run reset
    do_reset(2);
    ack_pct = 60; rv_pct = 70; stall_pct = 30; lat_max = 3; spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        do_reset(1);
      end else if (i == 700) begin
        run_cycle(1'b1, 32'hFFFF_FFF2);
      end else begin
        run_cycle($urandom_range(99) < 3, $urandom());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
